// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - pipelined opcode decoder with load-use stall, flush bubbles and illegal-opcode counter
//
// Decodes the ID-stage opcode and carries the control bundle through the
// ID/EX, EX/MEM and MEM/WB registers.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   id_valid        ID stage holds a real instruction
//   id_opcode       ID-stage opcode
//   id_rs, id_rt    ID-stage register specifiers
//   flush           taken branch; kill the ID instruction this cycle
//   stall           load-use hazard, fetch/ID must hold (combinational)
//   ex_*            EX-stage control: reg_dst, alu_src, alu_op, beq, bne, rt
//   mem_*           MEM-stage control: read, write
//   wb_*            WB-stage control: reg_write, mem_to_reg
//   illegal_cnt     saturating count of unknown opcodes accepted into ID/EX
module pipe_control_unit #(
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_opcode,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               flush,
    output logic               stall,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_beq,
    output logic               ex_bne,
    output logic [REG_W-1:0]   ex_rt,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h12);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2b);
    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h09);
    localparam logic [OP_W-1:0] OP_ADDU = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'h0c);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h04);

    // Decoded ID-stage bundle
    logic               decRegDst, decRegWrite, decMemToReg, decMemRead;
    logic               decMemWrite, decAluSrc, decBeq, decBne, decKnown;
    logic [ALUOP_W-1:0] decAluOp;

    // EX-stage fields that are not ports themselves
    logic exMemRead, exMemWrite, exRegWrite, exMemToReg;
    // MEM-stage fields headed for WB
    logic memRegWrite, memMemToReg;

    logic accept;

    always_comb begin
        decRegDst   = 1'b0;
        decRegWrite = 1'b0;
        decMemToReg = 1'b0;
        decMemRead  = 1'b0;
        decMemWrite = 1'b0;
        decAluSrc   = 1'b0;
        decAluOp    = '0;
        decBeq      = 1'b0;
        decBne      = 1'b0;
        decKnown    = 1'b1;
        case (id_opcode)
            OP_NOP:  ;
            OP_LW:   begin decRegWrite = 1'b1; decMemToReg = 1'b1; decMemRead = 1'b1; decAluSrc = 1'b1; end
            OP_SW:   begin decMemWrite = 1'b1; decAluSrc = 1'b1; end
            OP_R:    begin decRegDst = 1'b1; decRegWrite = 1'b1; decAluOp = ALUOP_W'(2); end
            OP_ADDI: begin decRegWrite = 1'b1; decAluSrc = 1'b1; end
            OP_ADDU: begin decRegWrite = 1'b1; decAluSrc = 1'b1; decAluOp = ALUOP_W'(1); end
            OP_ANDI: begin decRegWrite = 1'b1; decAluOp = ALUOP_W'(3); end
            OP_BEQ:  begin decAluOp = ALUOP_W'(4); decBeq = 1'b1; end
            OP_BNE:  begin decAluOp = ALUOP_W'(5); decBne = 1'b1; end
            default: decKnown = 1'b0;
        endcase
    end

    // r0 is never a real load destination, so it cannot create a hazard.
    assign stall = id_valid & exMemRead & (ex_rt != '0)
                 & ((id_rs == ex_rt) | (id_rt == ex_rt)) & ~flush;

    assign accept = id_valid & ~flush & ~stall;

    // ID/EX: anything not accepted (flush, stall, empty ID) becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_reg_dst <= 1'b0;
            ex_alu_src <= 1'b0;
            ex_alu_op  <= '0;
            ex_beq     <= 1'b0;
            ex_bne     <= 1'b0;
            ex_rt      <= '0;
            exMemRead  <= 1'b0;
            exMemWrite <= 1'b0;
            exRegWrite <= 1'b0;
            exMemToReg <= 1'b0;
        end else if (accept && decKnown) begin
            ex_reg_dst <= decRegDst;
            ex_alu_src <= decAluSrc;
            ex_alu_op  <= decAluOp;
            ex_beq     <= decBeq;
            ex_bne     <= decBne;
            ex_rt      <= id_rt;
            exMemRead  <= decMemRead;
            exMemWrite <= decMemWrite;
            exRegWrite <= decRegWrite;
            exMemToReg <= decMemToReg;
        end else begin
            ex_reg_dst <= 1'b0;
            ex_alu_src <= 1'b0;
            ex_alu_op  <= '0;
            ex_beq     <= 1'b0;
            ex_bne     <= 1'b0;
            ex_rt      <= '0;
            exMemRead  <= 1'b0;
            exMemWrite <= 1'b0;
            exRegWrite <= 1'b0;
            exMemToReg <= 1'b0;
        end
    end

    // EX/MEM and MEM/WB free-run; a bubble simply propagates as zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            memRegWrite   <= 1'b0;
            memMemToReg   <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
        end else begin
            mem_read      <= exMemRead;
            mem_write     <= exMemWrite;
            memRegWrite   <= exRegWrite;
            memMemToReg   <= exMemToReg;
            wb_reg_write  <= memRegWrite;
            wb_mem_to_reg <= memMemToReg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && !decKnown && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule
